absorb_squeeze_ctrl: RTL

//  Sequencer for the SHAKE sponge between the load stage and the dump stage.

---
 rtl/absorb_squeeze_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/absorb_squeeze_ctrl.sv
// absorb_squeeze_ctrl
//   Sequencer for the SHAKE sponge between the load stage and the dump stage.
//   It accepts full rate blocks from the load stage and drives clear, absorb
//   and round enables for the Keccak-f[1600] datapath. After the final block it
//   alternates squeeze handshakes and permutations until output_size bits have
//   been released. It owns the round counter and the remaining-bits counter
//   but never touches the state data itself.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   block_ready_i       load stage holds a full rate block (level)
//   last_block_i        offered block is the message's final block
//   operation_mode_i    2'b00 = SHAKE128, otherwise SHAKE256 (latched at start)
//   output_size_i       requested output bits (latched at start)
//   block_consumed_o    pulse: input block absorbed, buffer may be refilled
//   state_clear_o       pulse: zero the 1600-bit state
//   absorb_en_o         pulse: state[rate] ^= input buffer
//   round_en_o          apply one round this cycle
//   round_idx_o         round constant index
//   rate_sel_o          0 = 1344-bit rate, 1 = 1088-bit rate
//   squeeze_valid_o     rate portion of the state is valid for the dump stage
//   squeeze_ready_i     dump stage accepts the squeeze block
//   squeeze_bits_o      valid bits in the current squeeze block
//   squeeze_last_o      current squeeze block is the final one
//   busy_o              sequencer not idle
module absorb_squeeze_ctrl #(
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned RATE_128   = 1344,
    parameter int unsigned RATE_256   = 1088
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        block_ready_i,
    input  logic        last_block_i,
    input  logic [1:0]  operation_mode_i,
    input  logic [31:0] output_size_i,
    output logic        block_consumed_o,
    output logic        state_clear_o,
    output logic        absorb_en_o,
    output logic        round_en_o,
    output logic [4:0]  round_idx_o,
    output logic        rate_sel_o,
    output logic        squeeze_valid_o,
    input  logic        squeeze_ready_i,
    output logic [10:0] squeeze_bits_o,
    output logic        squeeze_last_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ABSORB,
        S_PERMUTE,
        S_WAIT_BLK,
        S_SQUEEZE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  round_cnt_q, round_cnt_d;
    logic [31:0] remaining_q, remaining_d;
    logic        last_flag_q, last_flag_d;
    logic        rate_sel_q, rate_sel_d;
    logic [31:0] rate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_cnt_q <= '0;
            remaining_q <= '0;
            last_flag_q <= 1'b0;
            rate_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            remaining_q <= remaining_d;
            last_flag_q <= last_flag_d;
            rate_sel_q  <= rate_sel_d;
        end
    end

    always_comb begin
        rate = rate_sel_q ? 32'(RATE_256) : 32'(RATE_128);
    end

    always_comb begin
        state_d          = state_q;
        round_cnt_d      = round_cnt_q;
        remaining_d      = remaining_q;
        last_flag_d      = last_flag_q;
        rate_sel_d       = rate_sel_q;
        block_consumed_o = 1'b0;
        state_clear_o    = 1'b0;
        absorb_en_o      = 1'b0;
        round_en_o       = 1'b0;
        round_idx_o      = '0;
        squeeze_valid_o  = 1'b0;
        squeeze_bits_o   = '0;
        squeeze_last_o   = 1'b0;
        busy_o           = (state_q != S_IDLE);
        rate_sel_o       = rate_sel_q;

        case (state_q)
            S_IDLE: begin
                if (block_ready_i) begin
                    rate_sel_d  = (operation_mode_i != 2'b00);
                    remaining_d = output_size_i;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_clear_o = 1'b1;
                state_d       = S_ABSORB;
            end
            S_ABSORB: begin
                absorb_en_o      = 1'b1;
                block_consumed_o = 1'b1;
                last_flag_d      = last_block_i;
                round_cnt_d      = '0;
                state_d          = S_PERMUTE;
            end
            S_PERMUTE: begin
                round_en_o  = 1'b1;
                round_idx_o = round_cnt_q;
                if (round_cnt_q == 5'(NUM_ROUNDS - 1)) begin
                    round_cnt_d = '0;
                    if (!last_flag_q)
                        state_d = S_WAIT_BLK;
                    else if (remaining_q != '0)
                        state_d = S_SQUEEZE;
                    else
                        state_d = S_IDLE;
                end else begin
                    round_cnt_d = round_cnt_q + 5'd1;
                end
            end
            S_WAIT_BLK: begin
                if (block_ready_i)
                    state_d = S_ABSORB;
            end
            S_SQUEEZE: begin
                // bits/last are only driven while squeezing so that every
                // output reads zero out of reset (remaining==0 would make
                // the raw last flag 1).
                squeeze_valid_o = 1'b1;
                squeeze_bits_o  = (remaining_q >= rate) ? rate[10:0] : remaining_q[10:0];
                squeeze_last_o  = (remaining_q <= rate);
                if (squeeze_ready_i) begin
                    if (remaining_q <= rate) begin
                        remaining_d = '0;
                        state_d     = S_IDLE;
                    end else begin
                        remaining_d = remaining_q - rate;
                        round_cnt_d = '0;
                        state_d     = S_PERMUTE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
